// File: rtl/f36_ll8_bridge_pkg.sv
// Shared field layout for the fifo36 word format and the 11-bit LocalLink byte entry.
package f36_ll8_bridge_pkg;

    localparam int unsigned F36_W      = 36;
    localparam int unsigned F36_SOF    = 32;
    localparam int unsigned F36_EOF    = 33;
    localparam int unsigned F36_OCC_LO = 34;
    localparam int unsigned F36_OCC_HI = 35;

    localparam int unsigned LL8_W    = 11;
    localparam int unsigned LL8_DATA = 0;
    localparam int unsigned LL8_SOF  = 8;
    localparam int unsigned LL8_EOF  = 9;
    localparam int unsigned LL8_ERR  = 10;

    // Index of the final valid byte in a word; occupancy 0 means all four bytes.
    function automatic logic [1:0] f36_last_byte(input logic [1:0] occ);
        return (occ == 2'd0) ? 2'd3 : occ - 2'd1;
    endfunction

    function automatic logic [LL8_W-1:0] ll8_pack(input logic [7:0] data, input logic sof,
                                                  input logic eof, input logic err);
        logic [LL8_W-1:0] e;
        e = '0;
        e[LL8_DATA +: 8] = data;
        e[LL8_SOF]       = sof;
        e[LL8_EOF]       = eof;
        e[LL8_ERR]       = err;
        return e;
    endfunction

endpackage

// File: rtl/ll8_sfifo16.sv
// Short synchronous FIFO for LocalLink byte entries; head entry is presented combinationally.
module ll8_sfifo16
    import f36_ll8_bridge_pkg::*;
#(
    parameter int unsigned Aw    = 4,
    parameter int unsigned Width = LL8_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [Width-1:0] data_i,
    input  logic             src_rdy_i,
    output logic             dst_rdy_o,
    output logic [Width-1:0] data_o,
    output logic             src_rdy_o,
    input  logic             dst_rdy_i
);

    localparam int unsigned Depth = 1 << Aw;

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [Aw:0]      count_q, count_d;
    logic             full, empty, wr_en, rd_en;

    // Count never exceeds Depth, so its MSB alone flags full.
    assign full  = count_q[Aw];
    assign empty = (count_q == '0);
    assign wr_en = src_rdy_i & ~full;
    assign rd_en = dst_rdy_i & ~empty;

    assign dst_rdy_o = ~full;
    assign src_rdy_o = ~empty;
    assign data_o    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/f36_ll8_bridge.sv
// fifo36 <-> LocalLink 8-bit bridge: TX unpacks words into bytes, RX packs bytes into words,
// each path decoupled from the MAC side by a short FIFO.
module f36_ll8_bridge
    import f36_ll8_bridge_pkg::*;
#(
    parameter int unsigned SFIFO_AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,

    input  logic [35:0] tx_f36_data,
    input  logic        tx_f36_src_rdy,
    output logic        tx_f36_dst_rdy,
    output logic [7:0]  tx_ll_data,
    output logic        tx_ll_sof,
    output logic        tx_ll_eof,
    output logic        tx_ll_error,
    output logic        tx_ll_src_rdy,
    input  logic        tx_ll_dst_rdy,

    input  logic [7:0]  rx_ll_data,
    input  logic        rx_ll_sof,
    input  logic        rx_ll_eof,
    input  logic        rx_ll_error,
    input  logic        rx_ll_src_rdy,
    output logic        rx_ll_dst_rdy,
    output logic [35:0] rx_f36_data,
    output logic        rx_f36_src_rdy,
    input  logic        rx_f36_dst_rdy
);

    // ---------------- TX: unpack words into the byte FIFO ----------------
    logic [1:0]       bi_q, bi_d;
    logic [1:0]       tx_occ, tx_last;
    logic [7:0]       tx_byte;
    logic             tx_fifo_rdy, tx_wr;
    logic [LL8_W-1:0] tx_entry, tx_head;

    assign tx_occ  = tx_f36_data[F36_OCC_HI:F36_OCC_LO];
    assign tx_last = f36_last_byte(tx_occ);

    always_comb begin
        tx_byte = '0;
        unique case (bi_q)
            2'd0: tx_byte = tx_f36_data[31:24];
            2'd1: tx_byte = tx_f36_data[23:16];
            2'd2: tx_byte = tx_f36_data[15:8];
            2'd3: tx_byte = tx_f36_data[7:0];
        endcase
    end

    // An errored word (SOF and EOF both set) falls out naturally as a one-word packet.
    assign tx_entry = ll8_pack(tx_byte,
                               tx_f36_data[F36_SOF] & (bi_q == 2'd0),
                               tx_f36_data[F36_EOF] & (bi_q == tx_last),
                               1'b0);

    assign tx_wr          = tx_f36_src_rdy & tx_fifo_rdy;
    assign tx_f36_dst_rdy = tx_fifo_rdy & (bi_q == tx_last);

    always_comb begin
        bi_d = bi_q;
        if (tx_wr) bi_d = (bi_q == tx_last) ? 2'd0 : bi_q + 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     bi_q <= '0;
        else if (clear) bi_q <= '0;
        else            bi_q <= bi_d;
    end

    ll8_sfifo16 #(
        .Aw    (SFIFO_AW),
        .Width (LL8_W)
    ) u_tx_fifo (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clear_i   (clear),
        .data_i    (tx_entry),
        .src_rdy_i (tx_f36_src_rdy),
        .dst_rdy_o (tx_fifo_rdy),
        .data_o    (tx_head),
        .src_rdy_o (tx_ll_src_rdy),
        .dst_rdy_i (tx_ll_dst_rdy)
    );

    assign tx_ll_data  = tx_head[LL8_DATA +: 8];
    assign tx_ll_sof   = tx_head[LL8_SOF];
    assign tx_ll_eof   = tx_head[LL8_EOF];
    assign tx_ll_error = tx_head[LL8_ERR];

    // ---------------- RX: byte FIFO then pack into words ----------------
    logic [LL8_W-1:0] rx_head;
    logic             rx_head_vld, rx_pack_rdy, rx_rd;
    logic [7:0]       rx_byte;
    logic             rx_b_sof, rx_b_eof, rx_b_err;
    logic [31:0]      acc_q, acc_d, acc_new;
    logic [1:0]       cnt_q, cnt_d;
    logic             sof_q, sof_d, first_sof, complete;
    logic             held_q, held_d;
    logic [35:0]      word_q, word_d;

    ll8_sfifo16 #(
        .Aw    (SFIFO_AW),
        .Width (LL8_W)
    ) u_rx_fifo (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clear_i   (clear),
        .data_i    (ll8_pack(rx_ll_data, rx_ll_sof, rx_ll_eof, rx_ll_error)),
        .src_rdy_i (rx_ll_src_rdy),
        .dst_rdy_o (rx_ll_dst_rdy),
        .data_o    (rx_head),
        .src_rdy_o (rx_head_vld),
        .dst_rdy_i (rx_pack_rdy)
    );

    // Packer takes a byte whenever the output word is free or draining this cycle.
    assign rx_pack_rdy = ~held_q | rx_f36_dst_rdy;
    assign rx_rd       = rx_head_vld & rx_pack_rdy;

    assign rx_byte  = rx_head[LL8_DATA +: 8];
    assign rx_b_sof = rx_head[LL8_SOF];
    assign rx_b_eof = rx_head[LL8_EOF];
    assign rx_b_err = rx_head[LL8_ERR];

    assign first_sof = (cnt_q == 2'd0) ? rx_b_sof : sof_q;
    assign complete  = (cnt_q == 2'd3) | rx_b_eof | rx_b_err;

    always_comb begin
        acc_new = (cnt_q == 2'd0) ? '0 : acc_q;
        unique case (cnt_q)
            2'd0: acc_new[31:24] = rx_byte;
            2'd1: acc_new[23:16] = rx_byte;
            2'd2: acc_new[15:8]  = rx_byte;
            2'd3: acc_new[7:0]   = rx_byte;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        sof_d  = sof_q;
        held_d = held_q;
        word_d = word_q;
        if (held_q & rx_f36_dst_rdy) held_d = 1'b0;
        if (rx_rd) begin
            if (complete) begin
                word_d[31:0] = acc_new;
                if (rx_b_err) begin
                    word_d[35:32] = 4'b0011;
                end else if (rx_b_eof) begin
                    // Byte count mod 4 is exactly the occupancy code.
                    word_d[35:32] = {cnt_q + 2'd1, 1'b1, first_sof};
                end else begin
                    word_d[35:32] = {2'b00, 1'b0, first_sof};
                end
                held_d = 1'b1;
                cnt_d  = '0;
                sof_d  = 1'b0;
            end else begin
                acc_d = acc_new;
                cnt_d = cnt_q + 2'd1;
                sof_d = first_sof;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            sof_q  <= 1'b0;
            held_q <= 1'b0;
            word_q <= '0;
        end else if (clear) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            sof_q  <= 1'b0;
            held_q <= 1'b0;
            word_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            sof_q  <= sof_d;
            held_q <= held_d;
            word_q <= word_d;
        end
    end

    assign rx_f36_data    = word_q;
    assign rx_f36_src_rdy = held_q;

endmodule

// File: tb/tb_f36_ll8_bridge.sv
// Directed bench for f36_ll8_bridge: packet vectors with byte/word scoreboards built by the bench.
`timescale 1ns/1ps
module tb_f36_ll8_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [35:0] tx_f36_data = '0;
    logic        tx_f36_src_rdy = 1'b0;
    logic        tx_f36_dst_rdy;
    logic [7:0]  tx_ll_data;
    logic        tx_ll_sof, tx_ll_eof, tx_ll_error, tx_ll_src_rdy;
    logic        tx_ll_dst_rdy = 1'b1;
    logic [7:0]  rx_ll_data = '0;
    logic        rx_ll_sof = 1'b0, rx_ll_eof = 1'b0, rx_ll_error = 1'b0;
    logic        rx_ll_src_rdy = 1'b0;
    logic        rx_ll_dst_rdy;
    logic [35:0] rx_f36_data;
    logic        rx_f36_src_rdy;
    logic        rx_f36_dst_rdy = 1'b1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned rx_sent = 0;
    logic        abort = 1'b0;
    logic [10:0] txq [$];
    logic [35:0] rxq [$];
    logic [35:0] rxm [$];
    logic [10:0] tx_exp;
    logic [35:0] rx_exp, rx_msk;

    f36_ll8_bridge #(.SFIFO_AW(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .tx_f36_data    (tx_f36_data),
        .tx_f36_src_rdy (tx_f36_src_rdy),
        .tx_f36_dst_rdy (tx_f36_dst_rdy),
        .tx_ll_data     (tx_ll_data),
        .tx_ll_sof      (tx_ll_sof),
        .tx_ll_eof      (tx_ll_eof),
        .tx_ll_error    (tx_ll_error),
        .tx_ll_src_rdy  (tx_ll_src_rdy),
        .tx_ll_dst_rdy  (tx_ll_dst_rdy),
        .rx_ll_data     (rx_ll_data),
        .rx_ll_sof      (rx_ll_sof),
        .rx_ll_eof      (rx_ll_eof),
        .rx_ll_error    (rx_ll_error),
        .rx_ll_src_rdy  (rx_ll_src_rdy),
        .rx_ll_dst_rdy  (rx_ll_dst_rdy),
        .rx_f36_data    (rx_f36_data),
        .rx_f36_src_rdy (rx_f36_src_rdy),
        .rx_f36_dst_rdy (rx_f36_dst_rdy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input int seed, input int k);
        return 8'(seed * 16 + k * 3 + 7);
    endfunction

    // Transfers are decided at the negedge before the edge that performs them.
    always @(negedge clk) begin
        if (reset && tx_ll_src_rdy && tx_ll_dst_rdy) begin
            if (txq.size() == 0) begin
                check_eq("tx_extra_byte", 36'(txq.size()), 36'd1);
            end else begin
                tx_exp = txq.pop_front();
                check_eq("tx_byte", {25'b0, tx_ll_error, tx_ll_eof, tx_ll_sof, tx_ll_data},
                         {25'b0, tx_exp});
            end
        end
    end

    always @(negedge clk) begin
        if (reset && rx_f36_src_rdy && rx_f36_dst_rdy) begin
            if (rxq.size() == 0) begin
                check_eq("rx_extra_word", 36'(rxq.size()), 36'd1);
            end else begin
                rx_exp = rxq.pop_front();
                rx_msk = rxm.pop_front();
                check_eq("rx_word", rx_f36_data & rx_msk, rx_exp & rx_msk);
            end
        end
    end

    task automatic send_tx_packet(input int seed, input int len);
        int nw;
        nw = (len + 3) / 4;
        for (int k = 0; k < len; k++)
            txq.push_back({1'b0, k == len - 1, k == 0, pbyte(seed, k)});
        for (int w = 0; w < nw; w++) begin
            logic [35:0] word;
            logic [1:0]  occ;
            logic        eof, acc;
            int          cyc, exp_cyc;
            word = '0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < len) word[31 - 8 * b -: 8] = pbyte(seed, 4 * w + b);
            eof = (w == nw - 1);
            occ = eof ? 2'(len % 4) : 2'd0;
            word[35:32] = {occ, eof, w == 0};
            exp_cyc = (eof && occ != 0) ? int'(occ) : 4;
            tx_f36_data = word;
            tx_f36_src_rdy = 1'b1;
            cyc = 0;
            acc = 1'b0;
            do begin
                @(negedge clk);
                cyc++;
                acc = tx_f36_dst_rdy;
                @(posedge clk);
                #1;
            end while (!acc && cyc < 200 && !abort);
            if (abort) begin
                tx_f36_src_rdy = 1'b0;
                return;
            end
            check_eq("tx_word_accept", 36'(acc), 36'd1);
            check_eq("tx_word_cycles", 36'(cyc), 36'(exp_cyc));
        end
        tx_f36_src_rdy = 1'b0;
        tx_f36_data = '0;
    endtask

    task automatic send_rx_packet(input int seed, input int len, input logic err_last);
        int nw;
        nw = (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [35:0] word, msk;
            logic        eof;
            int          nb;
            word = '0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < len) word[31 - 8 * b -: 8] = pbyte(seed, 4 * w + b);
            eof = (w == nw - 1);
            nb = eof ? len - 4 * w : 4;
            msk = {4'hF, 32'hFFFF_FFFF << (8 * (4 - nb))};
            if (eof && err_last)  word[35:32] = 4'b0011;
            else if (eof)         word[35:32] = {2'(len % 4), 1'b1, w == 0};
            else                  word[35:32] = {2'b00, 1'b0, w == 0};
            rxq.push_back(word);
            rxm.push_back(msk);
        end
        for (int k = 0; k < len; k++) begin
            logic acc;
            int   cyc;
            rx_ll_data = pbyte(seed, k);
            rx_ll_sof = (k == 0);
            rx_ll_eof = (k == len - 1);
            rx_ll_error = err_last && (k == len - 1);
            rx_ll_src_rdy = 1'b1;
            cyc = 0;
            acc = 1'b0;
            do begin
                @(negedge clk);
                cyc++;
                acc = rx_ll_dst_rdy;
                if (acc) rx_sent++;
                @(posedge clk);
                #1;
            end while (!acc && cyc < 200 && !abort);
            if (abort) begin
                rx_ll_src_rdy = 1'b0;
                return;
            end
            check_eq("rx_byte_accept", 36'(acc), 36'd1);
        end
        rx_ll_src_rdy = 1'b0;
        rx_ll_sof = 1'b0;
        rx_ll_eof = 1'b0;
        rx_ll_error = 1'b0;
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while ((txq.size() != 0 || rxq.size() != 0) && c < 500) begin
            @(posedge clk);
            c++;
        end
        #1;
        check_eq({tag, "_tx_left"}, 36'(txq.size()), 36'd0);
        check_eq({tag, "_rx_left"}, 36'(rxq.size()), 36'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_tx_src_rdy"}, 36'(tx_ll_src_rdy), 36'd0);
        check_eq({tag, "_tx_ll_out"}, {25'b0, tx_ll_error, tx_ll_eof, tx_ll_sof, tx_ll_data}, 36'd0);
        check_eq({tag, "_tx_f36_dst"}, 36'(tx_f36_dst_rdy), 36'd0);
        check_eq({tag, "_rx_src_rdy"}, 36'(rx_f36_src_rdy), 36'd0);
        check_eq({tag, "_rx_data"}, rx_f36_data, 36'd0);
        check_eq({tag, "_rx_ll_dst"}, 36'(rx_ll_dst_rdy), 36'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b1;
        @(posedge clk);
        #1;

        send_tx_packet(1, 60);
        drain("tx60");
        for (int len = 61; len <= 63; len++) begin
            send_tx_packet(len, len);
            drain("tx6x");
        end

        rx_f36_dst_rdy = 1'b1;
        send_rx_packet(5, 61, 1'b0);
        drain("rx61");

        // Output word stalled from the start: 4 bytes packed, 16 more fill the FIFO.
        rx_f36_dst_rdy = 1'b0;
        rx_sent = 0;
        fork
            send_rx_packet(9, 61, 1'b0);
            begin
                repeat (30) @(negedge clk);
                check_eq("bp_rx_ll_dst_rdy", 36'(rx_ll_dst_rdy), 36'd0);
                check_eq("bp_bytes_taken", 36'(rx_sent), 36'd20);
                check_eq("bp_word_held", 36'(rx_f36_src_rdy), 36'd1);
                @(posedge clk);
                #1;
                rx_f36_dst_rdy = 1'b1;
            end
        join
        drain("rx_bp");

        send_rx_packet(11, 40, 1'b1);
        send_rx_packet(13, 8, 1'b0);
        drain("rx_err");

        fork
            send_tx_packet(15, 60);
            send_rx_packet(17, 61, 1'b0);
        join_none
        repeat (10) @(posedge clk);
        #3;
        abort = 1'b1;
        reset = 1'b0;
        #1;
        check_reset_values("mid");
        repeat (3) @(posedge clk);
        #1;
        txq.delete();
        rxq.delete();
        rxm.delete();
        abort = 1'b0;
        tx_f36_src_rdy = 1'b0;
        tx_f36_data = '0;
        rx_ll_src_rdy = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_tx_packet(19, 61);
        send_rx_packet(21, 62, 1'b0);
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
